// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational datapath ALU between two requesters. Each
// requester offers an operation on a valid/ready request channel and
// collects the result on a valid/ready response channel. At most one request
// is granted per cycle, round-robin. The granted operands drive the ALU in
// the same cycle, and the ALU result is captured into that requester's
// response register at the clock edge.
//
// Handshake rule (both channels, both requesters): a transfer happens on a
// rising edge where valid and ready are both 1. Ready never depends on the
// same channel's valid. A producer holds its payload stable while valid is 1
// and ready is 0.
//
// Parameters
//   DATA_WIDTH    operand/result width; must match the ALU instance
//
// Ports
//   clk           single clock, all state updates on the rising edge
//   rst_n         synchronous active-low reset
//   reqN_valid    requester N presents an operation            (N = 0,1)
//   reqN_ready    requester N's operation is accepted this cycle
//   reqN_op1/op2  operands
//   reqN_ctrl     ALU control code, passed through unchecked
//   respN_valid   response register N holds a result
//   respN_ready   requester N consumes the response
//   respN_out     captured ALU result
//   respN_eq      captured ALU EQ flag
//   alu_op1/op2   operands to the ALU
//   alu_ctrl      control code to the ALU (3'b111 when idle)
//   alu_out       ALU result (combinational)
//   alu_eq        ALU EQ flag (combinational)
//   prio          round-robin state: the requester favoured on a tie
// ---------------------------------------------------------------------------
module alu_arbiter #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [DATA_WIDTH-1:0] req0_op1,
   input  logic [DATA_WIDTH-1:0] req0_op2,
   input  logic [2:0]            req0_ctrl,

   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [DATA_WIDTH-1:0] req1_op1,
   input  logic [DATA_WIDTH-1:0] req1_op2,
   input  logic [2:0]            req1_ctrl,

   output logic                  resp0_valid,
   input  logic                  resp0_ready,
   output logic [DATA_WIDTH-1:0] resp0_out,
   output logic                  resp0_eq,

   output logic                  resp1_valid,
   input  logic                  resp1_ready,
   output logic [DATA_WIDTH-1:0] resp1_out,
   output logic                  resp1_eq,

   output logic [DATA_WIDTH-1:0] alu_op1,
   output logic [DATA_WIDTH-1:0] alu_op2,
   output logic [2:0]            alu_ctrl,
   input  logic [DATA_WIDTH-1:0] alu_out,
   input  logic                  alu_eq,

   output logic                  prio
);

   // Control code driven onto the ALU when nothing is granted. The ALU
   // returns 0 for it, so an idle ALU produces no switching result.
   localparam logic [2:0] CTRL_IDLE = 3'b111;

   logic slot0_free;
   logic slot1_free;
   logic acc0;
   logic acc1;

   // A response slot can take a new result if it is empty, or if its current
   // result is being consumed in this same cycle (drain and refill).
   assign slot0_free = !resp0_valid || resp0_ready;
   assign slot1_free = !resp1_valid || resp1_ready;

   // A requester is ready when its slot is free and it either holds priority
   // or the other requester cannot compete this cycle. When both requesters
   // are valid with free slots, exactly one of them is ready. Readiness is
   // forced low during reset so nothing is accepted while state is cleared.
   assign req0_ready = rst_n && slot0_free &&
                       (!prio || !(req1_valid && slot1_free));
   assign req1_ready = rst_n && slot1_free &&
                       ( prio || !(req0_valid && slot0_free));

   assign acc0 = req0_valid && req0_ready;
   assign acc1 = req1_valid && req1_ready;

   // Operand steering: the granted requester drives the ALU directly.
   always_comb begin
      alu_op1  = '0;
      alu_op2  = '0;
      alu_ctrl = CTRL_IDLE;
      if (acc0) begin
         alu_op1  = req0_op1;
         alu_op2  = req0_op2;
         alu_ctrl = req0_ctrl;
      end else if (acc1) begin
         alu_op1  = req1_op1;
         alu_op2  = req1_op2;
         alu_ctrl = req1_ctrl;
      end
   end

   // Response registers and round-robin priority.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resp0_valid <= 1'b0;
         resp0_out   <= '0;
         resp0_eq    <= 1'b0;
         resp1_valid <= 1'b0;
         resp1_out   <= '0;
         resp1_eq    <= 1'b0;
         prio        <= 1'b0;
      end else begin
         // Slot 0: load on accept, otherwise empty when consumed. The data
         // fields keep their last value once the response has been taken.
         if (acc0) begin
            resp0_valid <= 1'b1;
            resp0_out   <= alu_out;
            resp0_eq    <= alu_eq;
         end else if (resp0_ready) begin
            resp0_valid <= 1'b0;
         end

         if (acc1) begin
            resp1_valid <= 1'b1;
            resp1_out   <= alu_out;
            resp1_eq    <= alu_eq;
         end else if (resp1_ready) begin
            resp1_valid <= 1'b0;
         end

         // After a grant the other requester is favoured next time.
         if (acc0) begin
            prio <= 1'b1;
         end else if (acc1) begin
            prio <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Drives alu_arbiter with a behavioural ALU attached to its ALU ports.
// Expected results are computed from the bench's own operands and pushed
// into per-requester queues on each expected accept; they are popped when
// the response is consumed. A small model of the response slots and the
// round-robin priority gives the expected readiness each cycle.
// Inputs change on the falling edge; outputs are sampled 1 ns later
// (combinational) or on the next falling edge (registered).
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

   localparam int W = 32;

   logic         clk;
   logic         rst_n;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
   logic [2:0]   req0_ctrl, req1_ctrl;
   logic         resp0_valid, resp1_valid;
   logic         resp0_ready, resp1_ready;
   logic [W-1:0] resp0_out, resp1_out;
   logic         resp0_eq, resp1_eq;
   logic [W-1:0] alu_op1, alu_op2, alu_out;
   logic [2:0]   alu_ctrl;
   logic         alu_eq;
   logic         prio;

   int errors = 0;
   int checks = 0;

   // Scoreboard: {eq, result} per outstanding response.
   logic [W:0] exp_q0[$];
   logic [W:0] exp_q1[$];

   // Model state
   logic m_v0, m_v1, m_prio;

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural ALU ----------------
   function automatic logic [W:0] alu_fn(input logic [2:0] c,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
      logic [W-1:0] d;
      case (c)
         3'b000: alu_fn = {1'b0, a + b};
         3'b001: begin
            d = a - b;
            alu_fn = {(d == '0), d};
         end
         3'b010: alu_fn = {1'b0, a & b};
         3'b011: alu_fn = {1'b0, a | b};
         3'b101: alu_fn = {1'b0, {(W-1){1'b0}}, (a < b)};
         default: alu_fn = '0;
      endcase
   endfunction

   assign {alu_eq, alu_out} = alu_fn(alu_ctrl, alu_op1, alu_op2);

   // ---------------- DUT ----------------
   alu_arbiter #(.DATA_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp0_out(resp0_out), .resp0_eq(resp0_eq),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp1_out(resp1_out), .resp1_eq(resp1_eq),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
      .alu_out(alu_out), .alu_eq(alu_eq),
      .prio(prio)
   );

   // ---------------- driver / checker tasks ----------------

   // Registered outputs against the model; called on a falling edge.
   task automatic check_regs();
      checks++;
      if (resp0_valid !== m_v0) begin
         errors++;
         $display("FAIL resp0_valid: got %b want %b", resp0_valid, m_v0);
      end
      checks++;
      if (resp1_valid !== m_v1) begin
         errors++;
         $display("FAIL resp1_valid: got %b want %b", resp1_valid, m_v1);
      end
      checks++;
      if (prio !== m_prio) begin
         errors++;
         $display("FAIL prio: got %b want %b", prio, m_prio);
      end
      if (m_v0 && exp_q0.size() > 0) begin
         checks++;
         if ({resp0_eq, resp0_out} !== exp_q0[0]) begin
            errors++;
            $display("FAIL resp0_data: got eq=%b out=%h want eq=%b out=%h",
                     resp0_eq, resp0_out, exp_q0[0][W], exp_q0[0][W-1:0]);
         end
      end
      if (m_v1 && exp_q1.size() > 0) begin
         checks++;
         if ({resp1_eq, resp1_out} !== exp_q1[0]) begin
            errors++;
            $display("FAIL resp1_data: got eq=%b out=%h want eq=%b out=%h",
                     resp1_eq, resp1_out, exp_q1[0][W], exp_q1[0][W-1:0]);
         end
      end
   endtask

   // One clock cycle of stimulus with full checking.
   task automatic cycle(input logic v0, input logic [2:0] c0,
                        input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic rr0,
                        input logic v1, input logic [2:0] c1,
                        input logic [W-1:0] a1, input logic [W-1:0] b1,
                        input logic rr1);
      logic f0, f1, e_r0, e_r1, acc0, acc1;
      logic [W-1:0] e_op1, e_op2;
      logic [2:0]   e_ctrl;
      @(negedge clk);
      check_regs();
      req0_valid = v0; req0_ctrl = c0; req0_op1 = a0; req0_op2 = b0;
      req1_valid = v1; req1_ctrl = c1; req1_op1 = a1; req1_op2 = b1;
      resp0_ready = rr0; resp1_ready = rr1;
      #1;
      f0   = !m_v0 || rr0;
      f1   = !m_v1 || rr1;
      e_r0 = f0 && (!m_prio || !(v1 && f1));
      e_r1 = f1 && ( m_prio || !(v0 && f0));
      acc0 = v0 && e_r0;
      acc1 = v1 && e_r1;
      checks++;
      if (req0_ready !== e_r0) begin
         errors++;
         $display("FAIL req0_ready: got %b want %b", req0_ready, e_r0);
      end
      checks++;
      if (req1_ready !== e_r1) begin
         errors++;
         $display("FAIL req1_ready: got %b want %b", req1_ready, e_r1);
      end
      e_op1 = '0; e_op2 = '0; e_ctrl = 3'b111;
      if (acc0) begin
         e_op1 = a0; e_op2 = b0; e_ctrl = c0;
      end else if (acc1) begin
         e_op1 = a1; e_op2 = b1; e_ctrl = c1;
      end
      checks++;
      if ({alu_ctrl, alu_op1, alu_op2} !== {e_ctrl, e_op1, e_op2}) begin
         errors++;
         $display("FAIL alu_drive: got ctrl=%b op1=%h op2=%h want ctrl=%b op1=%h op2=%h",
                  alu_ctrl, alu_op1, alu_op2, e_ctrl, e_op1, e_op2);
      end
      // Scoreboard / model update for the coming edge.
      if (m_v0 && rr0 && exp_q0.size() > 0) void'(exp_q0.pop_front());
      if (m_v1 && rr1 && exp_q1.size() > 0) void'(exp_q1.pop_front());
      if (acc0) exp_q0.push_back(alu_fn(c0, a0, b0));
      if (acc1) exp_q1.push_back(alu_fn(c1, a1, b1));
      m_v0 = acc0 || (m_v0 && !rr0);
      m_v1 = acc1 || (m_v1 && !rr1);
      if (acc0) m_prio = 1'b1;
      else if (acc1) m_prio = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cycle(1'b0, 3'b000, '0, '0, 1'b1, 1'b0, 3'b000, '0, '0, 1'b1);
   endtask

   // Reset with both requesters presenting operations; leaves inputs idle.
   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req0_valid = 1'b1; req0_ctrl = 3'b000; req0_op1 = 32'd1; req0_op2 = 32'd2;
      req1_valid = 1'b1; req1_ctrl = 3'b000; req1_op1 = 32'd3; req1_op2 = 32'd4;
      resp0_ready = 1'b0; resp1_ready = 1'b0;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         errors++;
         $display("FAIL ready_in_reset: got %b%b want 00", req0_ready, req1_ready);
      end
      @(negedge clk);
      checks++;
      if ({resp0_valid, resp0_out, resp0_eq, resp1_valid, resp1_out, resp1_eq, prio} !== '0) begin
         errors++;
         $display("FAIL reset_state: got v0=%b o0=%h e0=%b v1=%b o1=%h e1=%b prio=%b want all 0",
                  resp0_valid, resp0_out, resp0_eq, resp1_valid, resp1_out, resp1_eq, prio);
      end
      rst_n = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      exp_q0.delete(); exp_q1.delete();
      m_v0 = 1'b0; m_v1 = 1'b0; m_prio = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      apply_reset();
   endtask

   task automatic test_add();
      cycle(1'b1, 3'b000, 32'd7, 32'd5, 1'b0, 1'b0, 3'b000, '0, '0, 1'b0);
      @(negedge clk);
      checks++;
      if ({resp0_valid, resp0_eq, resp0_out, prio} !== {1'b1, 1'b0, 32'd12, 1'b1}) begin
         errors++;
         $display("FAIL add_result: got v=%b eq=%b out=%0d prio=%b want v=1 eq=0 out=12 prio=1",
                  resp0_valid, resp0_eq, resp0_out, prio);
      end
      // drain
      cycle(1'b0, 3'b000, '0, '0, 1'b1, 1'b0, 3'b000, '0, '0, 1'b1);
      idle(1);
   endtask

   task automatic test_fairness();
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 3'b001, 32'd9, 32'd9, 1'b1, 1'b1, 3'b101, 32'd3, 32'd4, 1'b1);
         checks++;
         if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL fair_grant%0d: got r0=%b r1=%b want %s", i,
                     req0_ready, req1_ready, (i % 2 == 0) ? "req0" : "req1");
         end
      end
      idle(2);
   endtask

   task automatic test_backpressure();
      apply_reset();
      cycle(1'b0, 3'b000, '0, '0, 1'b1, 1'b1, 3'b011, 32'hA0, 32'h0B, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 3'b000, i, 32'd100, 1'b1, 1'b1, 3'b010, 32'hFF, 32'h0F, 1'b0);
         checks++;
         if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL bp_grant%0d: got r0=%b r1=%b want r0=1 r1=0", i,
                     req0_ready, req1_ready);
         end
      end
      // Drain slot 1: req1 must be granted in this same cycle.
      cycle(1'b1, 3'b000, 32'd1, 32'd1, 1'b1, 1'b1, 3'b010, 32'hFF, 32'h0F, 1'b1);
      checks++;
      if (req1_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: got r1=%b want 1", req1_ready);
      end
      idle(2);
   endtask

   task automatic test_illegal();
      cycle(1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 3'b000, '0, '0, 1'b1);
      @(negedge clk);
      checks++;
      if ({resp0_valid, resp0_eq, resp0_out} !== {1'b1, 1'b0, 32'd0}) begin
         errors++;
         $display("FAIL illegal_code: got v=%b eq=%b out=%h want v=1 eq=0 out=0",
                  resp0_valid, resp0_eq, resp0_out);
      end
      idle(3);
   endtask

   task automatic test_back_to_back();
      cycle(1'b1, 3'b011, 32'hF0, 32'h0F, 1'b1, 1'b0, 3'b000, '0, '0, 1'b1);
      cycle(1'b1, 3'b010, 32'hF0, 32'h0F, 1'b1, 1'b0, 3'b000, '0, '0, 1'b1);
      checks++;
      if ({req0_ready, resp0_valid, resp0_out} !== {1'b1, 1'b1, 32'hFF}) begin
         errors++;
         $display("FAIL b2b_first: got r0=%b v=%b out=%h want r0=1 v=1 out=ff",
                  req0_ready, resp0_valid, resp0_out);
      end
      cycle(1'b0, 3'b000, '0, '0, 1'b1, 1'b0, 3'b000, '0, '0, 1'b1);
      checks++;
      if ({resp0_valid, resp0_out} !== {1'b1, 32'h00}) begin
         errors++;
         $display("FAIL b2b_second: got v=%b out=%h want v=1 out=0", resp0_valid, resp0_out);
      end
      idle(1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++)
         cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
               1'($urandom_range(0, 1)));
      idle(2);
   endtask

   task automatic test_reset_midflight();
      cycle(1'b1, 3'b000, 32'd20, 32'd22, 1'b0, 1'b0, 3'b000, '0, '0, 1'b0);
      apply_reset();
      // First tie after reset goes to req0.
      cycle(1'b1, 3'b000, 32'd1, 32'd1, 1'b1, 1'b1, 3'b000, 32'd2, 32'd2, 1'b1);
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++;
         $display("FAIL post_reset_tie: got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
      end
      idle(2);
   endtask

   // ---------------- sequence ----------------
   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_op1 = '0; req0_op2 = '0; req0_ctrl = '0;
      req1_valid = 1'b0; req1_op1 = '0; req1_op2 = '0; req1_ctrl = '0;
      resp0_ready = 1'b0; resp1_ready = 1'b0;
      m_v0 = 1'b0; m_v1 = 1'b0; m_prio = 1'b0;

      test_reset();
      test_add();
      test_fairness();
      test_backpressure();
      test_illegal();
      test_back_to_back();
      test_random();
      test_reset_midflight();

      @(negedge clk);
      check_regs();
      checks++;
      if (exp_q0.size() + exp_q1.size() != int'(m_v0) + int'(m_v1)) begin
         errors++;
         $display("FAIL scoreboard_depth: got %0d entries want %0d",
                  exp_q0.size() + exp_q1.size(), int'(m_v0) + int'(m_v1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single datapath ALU between two requesters (e.g. the main execute path and an auxiliary address/compare unit) using valid/ready handshakes on both the request and response sides. Requests are granted round-robin, at most one per cycle. The granted operands drive the ALU combinationally, and the ALU result and EQ flag are captured into a per-requester response register. The block sits between the requesters and the ALU instance and owns the ALU's operand and control inputs.

## Interface
- DATA_WIDTH, 32, operand/result width; must match the ALU instance.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- reqN_valid  in  1  (N=0,1) requester N presents an operation.
- reqN_ready  out  1  requester N's operation is accepted this cycle.
- reqN_op1, reqN_op2  in  DATA_WIDTH  operands.
- reqN_ctrl  in  3  ALU control code, passed through unchecked.
- respN_valid  out  1  response register N holds a result.
- respN_ready  in  1  requester N consumes the response.
- respN_out  out  DATA_WIDTH  captured ALU result.
- respN_eq  out  1  captured ALU EQ flag.
- alu_op1, alu_op2  out  DATA_WIDTH  to the ALU.
- alu_ctrl  out  3  to the ALU.
- alu_out  in  DATA_WIDTH  from the ALU (combinational).
- alu_eq  in  1  from the ALU (combinational).

## Operation
- ALU codes:
  - 000 add
  - 001 sub (EQ=1 iff the difference is 0)
  - 010 and
  - 011 or
  - 101 unsigned less-than (result 1/0)
  - all other codes return 0
  - EQ is 0 for every code except 001.
- Slot N is "free" when respN_valid=0, or when respN_valid=1 and respN_ready=1 in the same cycle (drain and refill).
- Priority register prio (1 bit) names the favoured requester. Reset value 0.
- Readiness, with j = the other requester:
  - reqN_ready = slotN_free AND (prio==N OR NOT (reqj_valid AND slotj_free)).
  - reqN_ready never depends on reqN_valid.
  - req0_ready and req1_ready are never both 1 when both valids are 1.
- Accept N = reqN_valid AND reqN_ready. Only one accept can occur per cycle.
- On accept N:
  - alu_op1/op2/ctrl = reqN fields in the same cycle.
  - At the edge: respN_out ← alu_out, respN_eq ← alu_eq, respN_valid ← 1, prio ← j.
- No accept: alu_op1 = alu_op2 = 0, alu_ctrl = 3'b111. prio is unchanged.
- Response N with respN_ready=1 and no new accept: respN_valid ← 0. respN_out and respN_eq hold their last values.
- Response N with respN_ready=0: the register holds all fields. A requester with a full, undrained slot is never granted. The other requester may still be granted.
- Fairness: with both requesters continuously valid and draining, grants strictly alternate.

## Timing
- Reset (rst_n=0 at an edge):
  - respN_valid=0, respN_out=0, respN_eq=0, prio=0.
  - Any in-flight response is discarded.
  - reqN_ready is 0 while rst_n=0.
- Latency: accept in cycle t → respN_valid=1 with the result in cycle t+1.
- Throughput: one operation per cycle total. Each requester can sustain one per cycle when its response is drained every cycle and the other requester is idle.
- Simultaneous respN_ready and a new accept for N: the old result is consumed and the new result is loaded. respN_valid stays 1.
- Operands and ctrl must be stable only in the accept cycle. No buffering exists beyond the response register.
- No combinational path exists from respN_ready to respN_out or respN_eq.
- Combinational paths exist from reqN fields to alu_* outputs and from reqj_valid/respN_ready to reqN_ready.

## Test plan
- Reset, then req0 issues add 7+5 → req0_ready=1; next cycle resp0_valid=1, resp0_out=12, resp0_eq=0; prio=1.
- Both valid every cycle, responses always ready, req0 = sub 9-9, req1 = slt 3<4:
  - Grants alternate starting with req0.
  - resp0_out=0 with resp0_eq=1.
  - resp1_out=1 with resp1_eq=0.
- Backpressure: resp1_ready held 0 after one req1 result. req1_ready=0 on following cycles; req0 is granted every cycle. resp1_out holds until resp1_ready=1, then req1 is granted in that same cycle.
- Illegal code 110 on req0 with ops 0xFFFF_FFFF, 1 → resp0_out=0, resp0_eq=0. Idle cycles show alu_ctrl=111 and alu_op1=alu_op2=0.
- Back-to-back req0 (or 0xF0|0x0F, then and 0xF0&0x0F) with resp0_ready=1, req1 idle → accepts on consecutive cycles; resp0_out=0xFF then 0x00, resp0_valid continuous.
- Assert rst_n=0 while resp0_valid=1 and both requesters valid → the next cycle shows all resp outputs at 0 and prio=0; after release, req0 wins the first tie.
